mem_bus_arbiter: RTL

//  Shares the single main-memory port between the instruction-fetch refill path (I) and the

---
 rtl/mem_bus_arbiter.sv | 125 ++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// ============================================================================
//  Module      : mem_bus_arbiter
//  Description : Round-robin burst arbiter sharing one memory port between the
//                instruction-refill (I) and data-cache (D) paths.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_bus_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int BURST_LEN  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_gnt,
    output logic                  i_rvalid,
    output logic [DATA_WIDTH-1:0] i_rdata,
    output logic                  i_done,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_wready,
    output logic                  d_done,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int BEAT_W   = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int STRIDE   = DATA_WIDTH / 8;
    localparam int OFF_BITS = $clog2(BURST_LEN * STRIDE);

    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {ADDR_WIDTH{1'b1}} << OFF_BITS;
    localparam logic [ADDR_WIDTH-1:0] STRIDE_A   = ADDR_WIDTH'(STRIDE);
    localparam logic [BEAT_W-1:0]     LAST_BEAT  = BEAT_W'(BURST_LEN - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t                state;
    logic [BEAT_W-1:0]     beat;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic                  last_served_d;
    logic                  pick_d;
    logic                  bursting;
    logic                  beat_ack;
    logic                  last_beat;

    // D wins only when alone or when I was the side served most recently
    assign pick_d    = d_req & (~i_req | ~last_served_d);
    assign bursting  = (state == BURST);
    assign beat_ack  = bursting & mem_ack;
    assign last_beat = (beat == LAST_BEAT);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            beat          <= '0;
            base_addr     <= '0;
            last_served_d <= 1'b1;
            i_gnt         <= 1'b0;
            d_gnt         <= 1'b0;
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_req | d_req) begin
                        state         <= BURST;
                        beat          <= '0;
                        base_addr     <= (pick_d ? d_addr : i_addr) & ALIGN_MASK;
                        last_served_d <= pick_d;
                        i_gnt         <= ~pick_d;
                        d_gnt         <= pick_d;
                        mem_req       <= 1'b1;
                        mem_we        <= pick_d & d_we;
                    end
                end
                BURST: begin
                    if (mem_ack) begin
                        if (last_beat) begin
                            state   <= IDLE;
                            beat    <= '0;
                            i_gnt   <= 1'b0;
                            d_gnt   <= 1'b0;
                            mem_req <= 1'b0;
                            mem_we  <= 1'b0;
                        end else begin
                            beat <= beat + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // mem_we doubles as the latched write flag for the granted burst
    assign mem_addr  = bursting ? (base_addr + ADDR_WIDTH'(beat) * STRIDE_A) : '0;
    assign mem_wdata = (d_gnt & mem_we) ? d_wdata : '0;

    assign i_rvalid  = beat_ack & i_gnt;
    assign i_done    = beat_ack & i_gnt & last_beat;
    assign i_rdata   = i_rvalid ? mem_rdata : '0;

    assign d_rvalid  = beat_ack & d_gnt & ~mem_we;
    assign d_wready  = beat_ack & d_gnt & mem_we;
    assign d_done    = beat_ack & d_gnt & last_beat;
    assign d_rdata   = d_rvalid ? mem_rdata : '0;

endmodule

`default_nettype wire
